ct_ifu_spsram16_ctrl: RTL

CT_IFU_SPSRAM16_CTRL -- requirements
Module: ct_ifu_spsram16_ctrl

---
 rtl/ct_ifu_spsram16_ctrl_pkg.sv | 13 +
 rtl/ct_ifu_spsram16_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/ct_ifu_spsram16_ctrl_pkg.sv
// Shared constants and FSM state type for the 128x16 IFU SRAM controller.
package ct_ifu_spsram16_ctrl_pkg;

  localparam int unsigned ADDR_WIDTH = 7;
  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned ENTRIES    = 1 << ADDR_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    INIT = 1'b1
  } state_t;

endpackage

// File: rtl/ct_ifu_spsram16_ctrl.sv
// Single-port 128x16 SRAM controller: sequential clear (INIT) after reset or on
// inval_req, then write-over-read arbitration with one-cycle read latency.
// Optional macro CT_IFU_SPSRAM16_RDHOLD_EN: rd_data holds the last read value
// between reads instead of being valid only while rd_vld is high.
module ct_ifu_spsram16_ctrl
  import ct_ifu_spsram16_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ct_ifu_spsram16_ctrl_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = ct_ifu_spsram16_ctrl_pkg::DATA_WIDTH
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  inval_req,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  wr_gnt,
  output logic                  rd_gnt,
  output logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  rd_vld_q;

  // State, clear counter and read-valid pipeline register
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_vld_q <= rd_gnt;
    end
  end

  // Next state, grants and SRAM pin drive; priority inval > write > read
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    init_done = 1'b0;
    wr_gnt    = 1'b0;
    rd_gnt    = 1'b0;
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    unique case (state_q)
      INIT: begin
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = '0;
        sram_a    = cnt_q;
        // A new invalidation restarts the sweep and suppresses the done pulse
        if (inval_req) begin
          cnt_d = '0;
        end else if (&cnt_q) begin
          init_done = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      IDLE: begin
        if (inval_req) begin
          state_d = INIT;
          cnt_d   = '0;
        end else if (wr_req) begin
          wr_gnt    = 1'b1;
          sram_cen  = 1'b0;
          sram_gwen = 1'b0;
          sram_a    = wr_addr;
          sram_d    = wr_data;
          sram_wen  = ~wr_mask;
        end else if (rd_req) begin
          rd_gnt   = 1'b1;
          sram_cen = 1'b0;
          sram_a   = rd_addr;
        end
      end
      default: begin
        state_d = INIT;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy   = (state_q == INIT);
  assign rd_vld = rd_vld_q;

`ifdef CT_IFU_SPSRAM16_RDHOLD_EN
  logic [DATA_WIDTH-1:0] rd_hold_q;

  // Capture SRAM output on each valid read so it survives until the next one
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rd_hold_q <= '0;
    end else if (rd_vld_q) begin
      rd_hold_q <= sram_q;
    end
  end

  // Pass sram_q through in the valid cycle so read latency stays one cycle
  assign rd_data = rd_vld_q ? sram_q : rd_hold_q;
`else
  assign rd_data = rd_vld_q ? sram_q : '0;
`endif

endmodule
